// File: rtl/licznik_pkg.sv
// Shared definitions for the licznik timer arbiter.
// Contents: the arbiter state enum, the timer ctrl-byte bit positions,
// the prescaler codes and a helper that assembles the ctrl byte.
package licznik_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_L,
    S_WR_H,
    S_WR_CTR,
    S_RUN,
    S_ACK,
    S_STOP
  } arb_state_t;

  // Bit positions inside the timer ctrl byte
  localparam int CTR_EN   = 7;
  localparam int CTR_TRYB = 4;
  localparam int CTR_IE   = 3;

  // Prescaler codes, placed unchanged in ctrl[2:0]
  localparam logic [2:0] PRESC_1    = 3'd1;
  localparam logic [2:0] PRESC_8    = 3'd2;
  localparam logic [2:0] PRESC_64   = 3'd3;
  localparam logic [2:0] PRESC_256  = 3'd4;
  localparam logic [2:0] PRESC_1024 = 3'd5;

  // Ctrl byte that starts the timer: {en=1, 00, tryb, ie, presc}
  function automatic logic [7:0] ctrl_byte(input logic mode, input logic ie,
                                           input logic [2:0] presc);
    logic [7:0] b;
    b           = '0;
    b[CTR_EN]   = 1'b1;
    b[CTR_TRYB] = mode;
    b[CTR_IE]   = ie;
    b[2:0]      = presc;
    return b;
  endfunction

endpackage

// File: rtl/licznik_arb_rr_arbiter.sv
// Round-robin arbiter, reusable for any shared peripheral.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   i_req      - request vector
//   i_advance  - accept the current winner; pointer moves past it
//   o_grant    - one-hot winner (combinational)
//   o_idx      - index of the winner
//   o_any      - at least one request present
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_advance,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] r_ptr;

  // Search starts at the pointer and wraps; first requester found wins.
  always_comb begin : search
    int cand;
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    cand    = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(r_ptr) + k) % N;
      if (!o_any && i_req[cand]) begin
        o_any = 1'b1;
        o_idx = IW'(cand);
      end
    end
    if (o_any) o_grant[o_idx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_advance && o_any) begin
      r_ptr <= IW'((int'(o_idx) + 1) % N);
    end
  end

endmodule

// File: rtl/licznik_arb.sv
// Shared-timer arbiter and configuration sequencer for the licznik timer.
// Grants the timer round-robin, programs it (L, H, ctr), turns the sticky
// timer flag into a one-cycle event for the owner, and stops the timer on
// release or after the first event of a oneshot owner.
// Ports:
//   req_valid/ready          - per-requester handshake (ready one-hot)
//   req_period/presc/mode/ie - per-requester timer configuration
//   req_oneshot/release      - auto-release after one event / give up timer
//   evt                      - one-cycle event pulse to the owner
//   busy, owner              - timer ownership status
//   t_*                      - timer write port, strobes and flag input
// All outputs are registered: each cycle the comb block computes the
// values for the next cycle and the flops present them.
module licznik_arb
  import licznik_pkg::*;
#(
  parameter int N_REQ = 2,
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*16-1:0] req_period,
  input  logic [N_REQ*3-1:0]  req_presc,
  input  logic [N_REQ-1:0]    req_mode,
  input  logic [N_REQ-1:0]    req_ie,
  input  logic [N_REQ-1:0]    req_oneshot,
  input  logic [N_REQ-1:0]    req_release,
  output logic [N_REQ-1:0]    evt,
  output logic              busy,
  output logic [OW-1:0]     owner,
  output logic [7:0]        t_wartosc,
  output logic              t_zapisz_L,
  output logic              t_zapisz_H,
  output logic              t_zapisz_ctr,
  output logic              t_flaga_clear,
  input  logic              t_flaga
);

  arb_state_t r_state, w_next;

  // Latched configuration of the current owner
  logic [15:0]   r_period;
  logic [2:0]    r_presc;
  logic          r_mode, r_ie, r_oneshot, r_pending;
  logic [OW-1:0] r_owner;

  // Registered outputs
  logic [N_REQ-1:0] r_req_ready, r_evt;
  logic             r_busy, r_zl, r_zh, r_zc, r_clr;
  logic [7:0]       r_wartosc;

  // Next-cycle values
  logic [N_REQ-1:0] w_req_ready, w_evt;
  logic             w_busy, w_zl, w_zh, w_zc, w_clr, w_pending;
  logic [7:0]       w_wartosc;

  logic [N_REQ-1:0] w_grant;
  logic [OW-1:0]    w_grant_idx;
  logic             w_any, w_advance, w_rel;
  logic [15:0]      w_sel_period;

  assign w_advance = (r_state == S_IDLE);
  // Release is honoured only from the owner
  assign w_rel     = req_release[r_owner];

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .i_req     (req_valid),
    .i_advance (w_advance),
    .o_grant   (w_grant),
    .o_idx     (w_grant_idx),
    .o_any     (w_any)
  );

  // Period clamp: below 2 the flag could re-set in the clear cycle.
  always_comb begin
    w_sel_period = req_period[int'(w_grant_idx)*16 +: 16];
    if (w_sel_period < 16'd2) w_sel_period = 16'd2;
  end

  always_comb begin
    w_next      = r_state;
    w_req_ready = '0;
    w_evt       = '0;
    w_busy      = r_busy;
    w_zl        = 1'b0;
    w_zh        = 1'b0;
    w_zc        = 1'b0;
    w_clr       = 1'b0;
    w_wartosc   = 8'h00;
    w_pending   = r_pending;
    unique case (r_state)
      S_IDLE: begin
        w_pending = 1'b0;
        if (w_any) begin
          w_req_ready = w_grant;
          w_busy      = 1'b1;
          w_next      = S_WR_L;
        end
      end
      S_WR_L: begin
        w_zl      = 1'b1;
        w_wartosc = r_period[7:0];
        w_pending = r_pending | w_rel;
        w_next    = S_WR_H;
      end
      S_WR_H: begin
        w_zh      = 1'b1;
        w_wartosc = r_period[15:8];
        w_pending = r_pending | w_rel;
        w_next    = S_WR_CTR;
      end
      S_WR_CTR: begin
        w_zc      = 1'b1;
        w_wartosc = ctrl_byte(r_mode, r_ie, r_presc);
        w_pending = r_pending | w_rel;
        w_next    = S_RUN;
      end
      S_RUN: begin
        if (t_flaga) begin
          // Flag beats a simultaneous release; the release waits for ACK.
          w_clr          = 1'b1;
          w_evt[r_owner] = 1'b1;
          w_pending      = r_pending | w_rel;
          w_next         = S_ACK;
        end else if (w_rel || r_pending) begin
          w_zc   = 1'b1;
          w_next = S_STOP;
        end
      end
      S_ACK: begin
        if (r_pending || w_rel || r_oneshot) begin
          w_zc   = 1'b1;
          w_next = S_STOP;
        end else begin
          w_next = S_RUN;
        end
      end
      S_STOP: begin
        w_busy    = 1'b0;
        w_pending = 1'b0;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: synchronous reset clears every flop, including the latched
    // configuration, so nothing stale survives into the next grant.
    if (rst) begin
      r_state     <= S_IDLE;
      r_period    <= '0;
      r_presc     <= '0;
      r_mode      <= 1'b0;
      r_ie        <= 1'b0;
      r_oneshot   <= 1'b0;
      r_pending   <= 1'b0;
      r_owner     <= '0;
      r_req_ready <= '0;
      r_evt       <= '0;
      r_busy      <= 1'b0;
      r_zl        <= 1'b0;
      r_zh        <= 1'b0;
      r_zc        <= 1'b0;
      r_clr       <= 1'b0;
      r_wartosc   <= 8'h00;
    end else begin
      r_state     <= w_next;
      r_pending   <= w_pending;
      r_req_ready <= w_req_ready;
      r_evt       <= w_evt;
      r_busy      <= w_busy;
      r_zl        <= w_zl;
      r_zh        <= w_zh;
      r_zc        <= w_zc;
      r_clr       <= w_clr;
      r_wartosc   <= w_wartosc;
      if (r_state == S_IDLE && w_any) begin
        r_owner   <= w_grant_idx;
        r_period  <= w_sel_period;
        r_presc   <= req_presc[int'(w_grant_idx)*3 +: 3];
        r_mode    <= req_mode[w_grant_idx];
        r_ie      <= req_ie[w_grant_idx];
        r_oneshot <= req_oneshot[w_grant_idx];
      end
    end
  end

  assign req_ready     = r_req_ready;
  assign evt           = r_evt;
  assign busy          = r_busy;
  assign owner         = r_owner;
  assign t_wartosc     = r_wartosc;
  assign t_zapisz_L    = r_zl;
  assign t_zapisz_H    = r_zh;
  assign t_zapisz_ctr  = r_zc;
  assign t_flaga_clear = r_clr;

endmodule

// File: doc/licznik_arb.md
# licznik_arb

Shared-timer arbiter and configuration sequencer for the 16-bit `licznik` peripheral. It grants the single timer to one of `N_REQ` requesters round-robin and programs it through its byte-wide write port in a fixed order: `zapisz_L`, then `zapisz_H`, then `zapisz_ctr`. It then converts the timer's sticky flag into a one-cycle event for the current owner and clears the flag. It sits between the requesters (CPU port, DMA/sequencer logic) and the timer instance.

## Interface
- `N_REQ`, default 2: number of requesters, 2..8.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in N_REQ: requester i asks for the timer.
- `req_ready` out N_REQ: one-hot; high in the cycle requester i is accepted.
- `req_period` in N_REQ×16: compare value, written to timer `wartosc_max`.
- `req_presc` in N_REQ×3: prescaler code, passed unchanged to timer ctrl bits [2:0].
- `req_mode` in N_REQ: timer `tryb`. 1 = overflow, 0 = compare.
- `req_ie` in N_REQ: timer `int_enable` bit.
- `req_oneshot` in N_REQ: release automatically after the first event.
- `req_release` in N_REQ: owner gives up the timer. Ignored from non-owners.
- `evt` out N_REQ: one-cycle pulse to the owner per timer event.
- `busy` out 1: timer is owned.
- `owner` out $clog2(N_REQ): index of the current owner. Valid while `busy` = 1.
- `t_wartosc` out 8: timer `wartosc`.
- `t_zapisz_L`, `t_zapisz_H`, `t_zapisz_ctr`, `t_flaga_clear` out 1 each: timer strobes.
- `t_flaga` in 1: timer `licznik_flaga`.

## Operation
States:
- **IDLE**: if any `req_valid`, grant the winner i. `req_ready[i]` = 1 that cycle. Latch period, presc, mode, ie and oneshot. Go to WR_L.
- **WR_L**: `t_zapisz_L` = 1, `t_wartosc` = period[7:0]. Go to WR_H.
- **WR_H**: `t_zapisz_H` = 1, `t_wartosc` = period[15:8]. Go to WR_CTR.
- **WR_CTR**: `t_zapisz_ctr` = 1, `t_wartosc` = {1, 00, mode, ie, presc}. Go to RUN.
- **RUN**:
  - `t_flaga` = 1: go to ACK.
  - Otherwise, `req_release[owner]` = 1: go to STOP.
- **ACK**: `t_flaga_clear` = 1 and `evt[owner]` = 1.
  - Pending release or oneshot: go to STOP.
  - Otherwise: go to RUN.
- **STOP**: `t_zapisz_ctr` = 1, `t_wartosc` = 0x00, which disables the timer and zeroes its flag. Go to IDLE, with `busy` = 0 from the next cycle.

Rules:
- Round-robin: pointer p = 0 after reset. Search starts at p. After granting i, p = (i+1) mod N_REQ.
- No preemption. Other requesters wait in IDLE with `req_valid` held high.
- Period clamp: a latched period below 2 is replaced by 2. Minimum period 2 keeps the flag from re-setting in the clear cycle.
- Release and flag in the same RUN cycle: the flag wins. The release is latched as pending and serviced after ACK. No event is lost.
- `req_release` during WR_L, WR_H or WR_CTR is latched as pending and acted on at the first RUN cycle.
- At most one strobe among {L, H, ctr} is high per cycle, which matches the timer's priority encoding.
- `t_wartosc` = 0 whenever no write strobe is high.

## Timing
- All outputs are registered. Reset value is 0 for every output; state = IDLE, pointer = 0, pending = 0.
- Accept to first strobe: `t_zapisz_L` is high in cycle T+1, where T is the `req_ready` cycle. `t_zapisz_H` at T+2, `t_zapisz_ctr` at T+3. RUN from T+4.
- Flag to event: `t_flaga` seen in RUN at cycle F gives `evt` and `t_flaga_clear` at F+1. The flag reads 0 from F+2.
- Release to free: `req_release` in RUN at cycle R gives the STOP strobe at R+1. IDLE and `busy` = 0 at R+2. Earliest new grant at R+2.
- `rst` mid-sequence: outputs go to 0 immediately and state returns to IDLE. The timer is reset by the same `rst`.

## Structure
- Package `licznik_pkg`:
  - state enum `arb_state_t`.
  - ctrl bit-position constants `CTR_EN = 7`, `CTR_TRYB = 4`, `CTR_IE = 3`.
  - prescaler code constants `PRESC_1`..`PRESC_1024`.
- Sub-module `rr_arbiter`: parameterised round-robin grant with pointer update. It is reusable for future shared peripherals.

## Test plan
- **Single grant:** requester 0 asks for period 0x1234, presc 001, mode 0, ie 1. Required: L strobe with 0x34, then H with 0x12, then ctr with 0x89 on consecutive cycles. First `evt[0]` arrives 0x1234 timer ticks after RUN.
- **Round-robin:** requesters 0 and 1 assert together, and 0 releases. Required: grant order 0, 1, then 0 again after 1 releases.
- **Oneshot:** period 5, oneshot. Required: exactly one `evt` pulse, then the STOP write of 0x00, then `busy` = 0.
- **Release and flag in the same cycle:** required: `evt` pulse, then STOP. Exactly one event and one STOP write.
- **Period clamp:** period 0 requested. Required: L = 0x02, H = 0x00.
- **Reset mid-sequence:** `rst` asserted in WR_H. Required: all outputs 0 next cycle, state IDLE, pointer 0.
